// File: rtl/rt_pkg.sv
// rtl/rt_pkg.sv - shared state enum, score width and LFSR constants for the reaction timer
package rt_pkg;

  localparam int SCORE_W = 24;
  localparam int LFSR_W  = 16;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    GO    = 3'd2,
    DONE  = 3'd3,
    FOUL  = 3'd4
  } rt_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/rt_tick.sv
// rtl/rt_tick.sv - free-running divider, one-clock tick every TICK_DIV clocks
module rt_tick #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign tick = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/reaction_timer.sv
// rtl/reaction_timer.sv - reaction timer FSM; RT_RANDOM_DELAY_EN adds an LFSR-randomised foreperiod
module reaction_timer
  import rt_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int DELAY_MIN = 1000,
  parameter int MAX_MS    = 9999
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b,
  output logic               led,
  output logic [SCORE_W-1:0] C,
  output logic               done,
  output logic               foul
);

  localparam int DLY_W = $clog2(DELAY_MIN + 4097);

  rt_state_e          state_q;
  logic [SCORE_W-1:0] score_q;
  logic [DLY_W-1:0]   delay_q;
  logic [DLY_W-1:0]   delay_load_d;
  logic               led_q;
  logic               done_q;
  logic               foul_q;
  logic               b_q;
  logic               tick;
  logic               press;

  rt_tick #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

`ifdef RT_RANDOM_DELAY_EN
  logic [LFSR_W-1:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign delay_load_d = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q[11:0]);
`else
  assign delay_load_d = DLY_W'(DELAY_MIN);
`endif

  assign press = b & ~b_q;

  // Press outranks a coincident tick or timeout in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= '0;
      delay_q <= '0;
      led_q   <= 1'b0;
      done_q  <= 1'b0;
      foul_q  <= 1'b0;
      b_q     <= 1'b0;
    end else begin
      b_q <= b;
      case (state_q)
        IDLE: begin
          if (press) begin
            delay_q <= delay_load_d;
            state_q <= ARMED;
          end
        end
        ARMED: begin
          if (press) begin
            state_q <= FOUL;
            foul_q  <= 1'b1;
            score_q <= '0;
          end else if (tick) begin
            if (delay_q <= DLY_W'(1)) begin
              state_q <= GO;
              led_q   <= 1'b1;
              score_q <= '0;
              delay_q <= '0;
            end else begin
              delay_q <= delay_q - DLY_W'(1);
            end
          end
        end
        GO: begin
          if (press) begin
            state_q <= DONE;
            led_q   <= 1'b0;
            done_q  <= 1'b1;
            if (score_q == '0) begin
              score_q <= SCORE_W'(1);
            end
          end else if (score_q >= SCORE_W'(MAX_MS)) begin
            state_q <= FOUL;
            led_q   <= 1'b0;
            foul_q  <= 1'b1;
            score_q <= '0;
          end else if (tick) begin
            score_q <= score_q + SCORE_W'(1);
          end
        end
        DONE, FOUL: begin
          // Score stays visible until the next GO so it survives the button release.
          if (press) begin
            delay_q <= delay_load_d;
            state_q <= ARMED;
            done_q  <= 1'b0;
            foul_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign led  = led_q;
  assign C    = score_q;
  assign done = done_q;
  assign foul = foul_q;

endmodule
